// File: rtl/hs_fifo_pkg.sv
// Shared types and default sizing for the hs_fifo elastic buffer stage.
package hs_fifo_pkg;

  // Default word width and storage depth (depth must be a power of two, >= 2).
  localparam int HS_DATA_WIDTH_DEF = 32;
  localparam int HS_DEPTH_DEF      = 4;

  // Upstream request FSM: IDLE has no request outstanding, BUSY holds req_l high.
  typedef enum logic [0:0] {
    REQ_IDLE = 1'b0,
    REQ_BUSY = 1'b1
  } req_state_e;

endpackage : hs_fifo_pkg

// File: rtl/hs_fifo_if.sv
// Pull-protocol req/ack channel of the dataflow fabric.
// The master issues req and receives a one-cycle ack with data valid in the
// same cycle; the slave answers requests.
interface hs_fifo_if
  import hs_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = HS_DATA_WIDTH_DEF
) ();

  logic                  req;
  logic                  ack;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output req,
    input  ack,
    input  data
  );

  modport slave (
    input  req,
    output ack,
    output data
  );

endinterface : hs_fifo_if

// File: rtl/hs_fifo_mem.sv
// Storage array for hs_fifo: synchronous write port, combinational read port.
// Contents are not reset; occupancy tracking in the parent decides validity.
module hs_fifo_mem
  import hs_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = HS_DATA_WIDTH_DEF,
  parameter  int DEPTH      = HS_DEPTH_DEF,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Capture the incoming word into the addressed slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : hs_fifo_mem

// File: rtl/hs_fifo.sv
// Elastic buffer stage between a fabric producer and consumer. Pulls words
// from upstream (one outstanding request at a time, only when a slot is free)
// and serves them downstream in order with a registered one-cycle ack.
module hs_fifo
  import hs_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = HS_DATA_WIDTH_DEF,
  parameter  int DEPTH      = HS_DEPTH_DEF,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  hs_fifo_if.master      up,
  hs_fifo_if.slave       dn,
  output logic [LW-1:0]  level
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  req_state_e            state_q, state_d;
  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ack_r_q, ack_r_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  push_s;
  logic                  pop_s;
  logic                  req_l_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  hs_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wp_q),
    .wdata_i (up.data),
    .raddr_i (rp_q),
    .rdata_o (rdata_s)
  );

  // Qualify handshake events: a stray ack at full is dropped; a pop needs a
  // stored word and a gap cycle after the previous ack.
  always_comb begin
    push_s = up.ack && (level_q < FULL_LVL);
    pop_s  = dn.req && !ack_r_q && (level_q != {LW{1'b0}});
  end

  // Next-state for pointers, occupancy and the downstream output registers.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    ack_r_d = 1'b0;
    dout_d  = dout_q;
    if (push_s) begin
      wp_d = wp_q + AW'(1);
    end else begin
      wp_d = wp_q;
    end
    if (pop_s) begin
      rp_d    = rp_q + AW'(1);
      ack_r_d = 1'b1;
      dout_d  = rdata_s;
    end else begin
      rp_d    = rp_q;
      ack_r_d = 1'b0;
      dout_d  = dout_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Datapath registers; reset empties the buffer and clears the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= {AW{1'b0}};
      rp_q    <= {AW{1'b0}};
      level_q <= {LW{1'b0}};
      ack_r_q <= 1'b0;
      dout_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ack_r_q <= ack_r_d;
      dout_q  <= dout_d;
    end
  end

  // Upstream request FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request next-state: raise only when the post-edge occupancy leaves a free
  // slot, so a pop at full re-arms the request on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_IDLE: begin
        if (!up.ack && (level_d < FULL_LVL)) begin
          state_d = REQ_BUSY;
        end else begin
          state_d = REQ_IDLE;
        end
      end
      REQ_BUSY: begin
        if (up.ack) begin
          state_d = REQ_IDLE;
        end else begin
          state_d = REQ_BUSY;
        end
      end
      default: state_d = REQ_IDLE;
    endcase
  end

  // Request output decode straight from the state register.
  always_comb begin
    req_l_s = 1'b0;
    case (state_q)
      REQ_BUSY: req_l_s = 1'b1;
      default:  req_l_s = 1'b0;
    endcase
  end

  assign up.req  = req_l_s;
  assign dn.ack  = ack_r_q;
  assign dn.data = dout_q;
  assign level   = level_q;

endmodule : hs_fifo

// File: tb/tb_hs_fifo.sv
// Directed bench for hs_fifo (depth 4, 32-bit words). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_hs_fifo;

  logic       clk;
  logic       rst;
  logic [2:0] level;

  int n_checks;
  int n_fail;

  // Background producer / consumer models, stepped by tick().
  logic        prod_en;
  logic        cons_en;
  logic [31:0] prod_val;
  int          prod_left;
  int          req_age;
  logic [31:0] cons_exp;
  int          cons_cnt;
  logic        prev_ack;

  hs_fifo_if #(.DATA_WIDTH(32)) up_bus ();
  hs_fifo_if #(.DATA_WIDTH(32)) dn_bus ();

  hs_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .up    (up_bus),
    .dn    (dn_bus),
    .level (level)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // One cycle: advance to the falling edge, then run the consumer and
  // producer models against what the DUT shows.
  task automatic tick();
    @(negedge clk);
    if (cons_en) begin
      if (dn_bus.ack) begin
        check_eq("stream_data", dn_bus.data, cons_exp);
        check_eq("ack_r_gap", 32'(prev_ack), 32'd0);
        cons_exp = cons_exp + 32'd1;
        cons_cnt++;
      end
      dn_bus.req = 1'b1;
    end
    prev_ack = dn_bus.ack;
    if (prod_en) begin
      if (up_bus.req) req_age++;
      else req_age = 0;
      if (up_bus.ack) begin
        up_bus.ack = 1'b0;
      end else if (up_bus.req && (req_age >= 2) && (prod_left > 0)) begin
        up_bus.ack  = 1'b1;
        up_bus.data = prod_val;
        prod_val    = prod_val + 32'd1;
        prod_left--;
      end
    end
  endtask

  // Manual push: wait (bounded) for req_l, then ack one word for one cycle.
  task automatic push_word(input logic [31:0] val);
    int w;
    w = 0;
    while (!up_bus.req && (w < 20)) begin
      @(negedge clk);
      w++;
    end
    check_eq("push_req_seen", 32'(up_bus.req), 32'd1);
    up_bus.ack  = 1'b1;
    up_bus.data = val;
    @(negedge clk);
    up_bus.ack  = 1'b0;
  endtask

  // Manual pop: one-cycle downstream request, check the acked word.
  task automatic pop_word(input logic [31:0] val);
    dn_bus.req = 1'b1;
    @(negedge clk);
    dn_bus.req = 1'b0;
    check_eq("pop_ack", 32'(dn_bus.ack), 32'd1);
    check_eq("pop_data", dn_bus.data, val);
    @(negedge clk);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    prod_en     = 1'b0;
    cons_en     = 1'b0;
    prod_val    = 32'd0;
    prod_left   = 0;
    req_age     = 0;
    cons_exp    = 32'd0;
    cons_cnt    = 0;
    prev_ack    = 1'b0;
    rst         = 1'b1;
    up_bus.ack  = 1'b0;
    up_bus.data = 32'd0;
    dn_bus.req  = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req_l", 32'(up_bus.req), 32'd0);
    check_eq("rst_ack_r", 32'(dn_bus.ack), 32'd0);
    check_eq("rst_dout", dn_bus.data, 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("first_req_l", 32'(up_bus.req), 32'd1);
    check_eq("first_level", 32'(level), 32'd0);
    @(negedge clk);

    // Fill with no consumer: level 1..4, request stays low at full.
    push_word(32'd10);
    check_eq("fill_lvl1", 32'(level), 32'd1);
    push_word(32'd11);
    check_eq("fill_lvl2", 32'(level), 32'd2);
    push_word(32'd12);
    check_eq("fill_lvl3", 32'(level), 32'd3);
    push_word(32'd13);
    check_eq("fill_lvl4", 32'(level), 32'd4);
    check_eq("full_req_l", 32'(up_bus.req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("full_req_l_hold", 32'(up_bus.req), 32'd0);
    // Stray ack at full must be dropped.
    up_bus.ack  = 1'b1;
    up_bus.data = 32'd99;
    @(negedge clk);
    up_bus.ack  = 1'b0;
    check_eq("full_drop_lvl", 32'(level), 32'd4);
    check_eq("full_drop_req_l", 32'(up_bus.req), 32'd0);

    // Single pop at full: ack for one cycle, request re-armed at the pop edge.
    dn_bus.req = 1'b1;
    @(negedge clk);
    dn_bus.req = 1'b0;
    check_eq("pfull_ack", 32'(dn_bus.ack), 32'd1);
    check_eq("pfull_dout", dn_bus.data, 32'd10);
    check_eq("pfull_req_l", 32'(up_bus.req), 32'd1);
    check_eq("pfull_lvl", 32'(level), 32'd3);
    @(negedge clk);
    check_eq("pfull_ack_drop", 32'(dn_bus.ack), 32'd0);
    check_eq("pfull_dout_hold", dn_bus.data, 32'd10);
    push_word(32'd14);
    check_eq("refill_lvl", 32'(level), 32'd4);

    // Simultaneous push and pop at level 2.
    pop_word(32'd11);
    pop_word(32'd12);
    check_eq("sim_pre_lvl", 32'(level), 32'd2);
    check_eq("sim_pre_req_l", 32'(up_bus.req), 32'd1);
    up_bus.ack  = 1'b1;
    up_bus.data = 32'd15;
    dn_bus.req  = 1'b1;
    @(negedge clk);
    up_bus.ack  = 1'b0;
    dn_bus.req  = 1'b0;
    check_eq("sim_lvl", 32'(level), 32'd2);
    check_eq("sim_ack", 32'(dn_bus.ack), 32'd1);
    check_eq("sim_dout", dn_bus.data, 32'd13);
    @(negedge clk);
    pop_word(32'd14);
    pop_word(32'd15);
    check_eq("drain_lvl", 32'(level), 32'd0);

    // Streaming: 5000 words from 0 through producer and consumer models.
    prod_val  = 32'd0;
    prod_left = 5000;
    req_age   = 0;
    cons_exp  = 32'd0;
    cons_cnt  = 0;
    prev_ack  = 1'b0;
    prod_en   = 1'b1;
    cons_en   = 1'b1;
    for (int c = 0; (c < 30000) && (cons_cnt < 5000); c++) begin
      tick();
    end
    check_eq("stream_count", 32'(cons_cnt), 32'd5000);
    prod_en    = 1'b0;
    cons_en    = 1'b0;
    dn_bus.req = 1'b0;
    up_bus.ack = 1'b0;
    @(negedge clk);
    check_eq("stream_end_lvl", 32'(level), 32'd0);

    // Reset with level 3 and an upstream ack in flight.
    push_word(32'd100);
    push_word(32'd101);
    push_word(32'd102);
    check_eq("rmid_pre_lvl", 32'(level), 32'd3);
    for (int w = 0; (w < 20) && !up_bus.req; w++) begin
      @(negedge clk);
    end
    check_eq("rmid_req_seen", 32'(up_bus.req), 32'd1);
    up_bus.ack  = 1'b1;
    up_bus.data = 32'd103;
    rst         = 1'b1;
    #1;
    check_eq("rmid_lvl_now", 32'(level), 32'd0);
    check_eq("rmid_ack_r_now", 32'(dn_bus.ack), 32'd0);
    check_eq("rmid_dout_now", dn_bus.data, 32'd0);
    check_eq("rmid_req_l_now", 32'(up_bus.req), 32'd0);
    @(negedge clk);
    check_eq("rmid_lvl_held", 32'(level), 32'd0);
    up_bus.ack = 1'b0;
    rst        = 1'b0;
    prod_val   = 32'd200;
    prod_left  = 3;
    req_age    = 0;
    cons_exp   = 32'd200;
    cons_cnt   = 0;
    prev_ack   = 1'b0;
    prod_en    = 1'b1;
    cons_en    = 1'b1;
    for (int c = 0; (c < 200) && (cons_cnt < 3); c++) begin
      tick();
    end
    check_eq("rmid_post_count", 32'(cons_cnt), 32'd3);
    prod_en    = 1'b0;
    cons_en    = 1'b0;
    dn_bus.req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hs_fifo
